sys_irq_ctrl: RTL

- Avalon-MM 16-bit slave interrupt controller.
- Sits directly downstream of the system timer and the other peripheral IRQ sources; drives the single CPU interrupt line.
- Collects up to NUM_IRQ request lines and latches edge-mode requests.
- Masks, prioritises (lowest index wins) and runs an acknowledge / end-of-interrupt handshake with the CPU.

---
 rtl/sys_irq_pkg.sv | 22 ++
 rtl/sys_irq_ctrl_prio_enc.sv | 21 ++
 rtl/sys_irq_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sys_irq_pkg.sv
// Shared constants and types for the sys_irq_ctrl interrupt controller.
// Register map addresses, FSM state encoding and VECTOR/INSVC field layout.
package sys_irq_pkg;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_VECTOR  = 3'd3;
    localparam logic [2:0] ADDR_EOI     = 3'd4;
    localparam logic [2:0] ADDR_INSVC   = 3'd5;

    localparam int DATA_W    = 16;
    localparam int VALID_BIT = 15;
    localparam int INDEX_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/sys_irq_ctrl_prio_enc.sv
// Combinational lowest-index-wins priority encoder with an any-set flag.
module sys_irq_prio_enc
    import sys_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [INDEX_W-1:0] idx,
    output logic               any
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = INDEX_W'(i);
        end
    end

endmodule

// File: rtl/sys_irq_ctrl.sv
// Avalon-MM 16-bit slave interrupt controller: edge/level capture, mask, priority, ack/EOI.
// Optional macro SYS_IRQ_CTRL_SYNC_EN adds a 2-flop input synchroniser on irq_in.
module sys_irq_ctrl
    import sys_irq_pkg::*;
#(
    parameter int                 NUM_IRQ    = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_RESET = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               read_n,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq,
    output logic               irq_active
);

    logic [NUM_IRQ-1:0] irq_s, s_q, rise;
    logic [NUM_IRQ-1:0] pending_q, pending_d, mask_q, edge_q, active, clr, eoi_mask;
    logic [INDEX_W-1:0] vec_q, vec_d, insvc_q, insvc_d, cand_idx;
    logic               cand_any, act_sel, ack_ok;
    logic               wr_en, rd_en, ack_rd, eoi_wr;
    logic [15:0]        rd_d;
    state_t             state_q, state_d;
    logic               unused_bits;

    assign unused_bits = ^writedata[15:NUM_IRQ];

`ifdef SYS_IRQ_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    assign wr_en  = chipselect & ~write_n;
    assign rd_en  = chipselect & ~read_n;
    assign ack_rd = rd_en && (address == ADDR_VECTOR);
    assign eoi_wr = wr_en && (address == ADDR_EOI) && (state_q == SERVICE);

    assign rise   = irq_s & ~s_q;
    assign active = pending_q & mask_q;

    sys_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req (active),
        .idx (cand_idx),
        .any (cand_any)
    );

    // Index-compare loops avoid variable bit-selects with a wider index.
    always_comb begin
        act_sel  = 1'b0;
        eoi_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (vec_q == INDEX_W'(i))   act_sel     = active[i];
            if (insvc_q == INDEX_W'(i)) eoi_mask[i] = eoi_wr;
        end
    end

    assign ack_ok = (state_q == REQ) && act_sel;

    // Edge lines: set beats clear in the same cycle. Level lines track the input.
    always_comb begin
        clr = eoi_mask;
        if (wr_en && (address == ADDR_PENDING)) clr = clr | writedata[NUM_IRQ-1:0];
        pending_d = (edge_q & ((pending_q & ~clr) | rise)) | (~edge_q & irq_s);
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        insvc_d = insvc_q;
        case (state_q)
            IDLE: begin
                if (cand_any) begin
                    vec_d   = cand_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!act_sel) begin
                    state_d = IDLE;
                end else if (ack_rd) begin
                    state_d = SERVICE;
                    insvc_d = vec_q;
                end
            end
            SERVICE: begin
                if (eoi_wr) begin
                    state_d = IDLE;
                    insvc_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_PENDING: rd_d[NUM_IRQ-1:0] = pending_q;
            ADDR_MASK:    rd_d[NUM_IRQ-1:0] = mask_q;
            ADDR_EDGE:    rd_d[NUM_IRQ-1:0] = edge_q;
            ADDR_VECTOR: begin
                rd_d[VALID_BIT]     = ack_ok;
                rd_d[INDEX_W-1:0]   = ack_ok ? vec_q : cand_idx;
            end
            ADDR_INSVC: begin
                rd_d[VALID_BIT]     = (state_q == SERVICE);
                rd_d[INDEX_W-1:0]   = insvc_q;
            end
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q        <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            edge_q     <= EDGE_RESET;
            vec_q      <= '0;
            insvc_q    <= '0;
            state_q    <= IDLE;
            readdata   <= '0;
            irq        <= 1'b0;
            irq_active <= 1'b0;
        end else begin
            s_q        <= irq_s;
            pending_q  <= pending_d;
            vec_q      <= vec_d;
            insvc_q    <= insvc_d;
            state_q    <= state_d;
            readdata   <= rd_d;
            irq        <= (state_d == REQ);
            irq_active <= (state_d == SERVICE);
            if (wr_en && (address == ADDR_MASK)) mask_q <= writedata[NUM_IRQ-1:0];
            if (wr_en && (address == ADDR_EDGE)) edge_q <= writedata[NUM_IRQ-1:0];
        end
    end

endmodule
